// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM encoding and the
// golden output tables of the 3-input simple_circuit datapath.
package truth_table_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    // Golden tables, bit k = output for input vector {A,B,C} = k.
    // D = (A & B) | ~C, E = ~C
    localparam logic [7:0] SC_EXP_D = 8'hD5;
    localparam logic [7:0] SC_EXP_E = 8'h55;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle timer: counts the cycles a stimulus vector has been held and flags
// the last settle cycle so the sequencer can move on to sampling.
module tt_settle_timer
    import truth_table_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // Cycle counter; clear has priority so a new vector always starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks every input vector of the datapath in
// ascending order, captures D/E after a settle time and checks the captured
// tables against the golden constants.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int                      N_IN          = 3,
    parameter int                      SETTLE_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0]    EXP_D         = SC_EXP_D,
    parameter logic [(1<<N_IN)-1:0]    EXP_E         = SC_EXP_E
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic [N_IN-1:0]        stim_o,
    input  logic                   d_i,
    input  logic                   e_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [N_IN-1:0]        vec_idx_o,
    output logic [(1<<N_IN)-1:0]   d_table_o,
    output logic [(1<<N_IN)-1:0]   e_table_o,
    output logic                   valid_o,
    output logic                   pass_o
);

    localparam int              N_VEC    = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);

    tt_state_e          state;
    logic               settle_tc;
    logic               timer_clear;
    logic               timer_en;
    logic [N_VEC-1:0]   d_next;
    logic [N_VEC-1:0]   e_next;

    // Timer restarts whenever a vector is (re)entered; it only runs while settling.
    assign timer_clear = abort_i || (state == ST_IDLE) || (state == ST_SAMPLE);
    assign timer_en    = (state == ST_SETTLE) && !settle_tc;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (settle_tc)
    );

    // Tables with the current sample merged in, so the verdict on the final
    // vector is available on the same edge that captures it.
    always_comb begin
        d_next            = d_table_o;
        e_next            = e_table_o;
        d_next[vec_idx_o] = d_i;
        e_next[vec_idx_o] = e_i;
    end

    // Sequencer FSM with all outputs registered; abort returns to IDLE but
    // keeps the partial tables, flagged invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stim_o    <= '0;
            vec_idx_o <= '0;
            d_table_o <= '0;
            e_table_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            valid_o   <= 1'b0;
            pass_o    <= 1'b0;
        end else if (abort_i) begin
            state   <= ST_IDLE;
            stim_o  <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            valid_o <= 1'b0;
            pass_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    stim_o <= '0;
                    if (start_i) begin
                        state     <= ST_SETTLE;
                        vec_idx_o <= '0;
                        busy_o    <= 1'b1;
                        valid_o   <= 1'b0;
                        pass_o    <= 1'b0;
                        d_table_o <= '0;
                        e_table_o <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_tc) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    d_table_o <= d_next;
                    e_table_o <= e_next;
                    if (vec_idx_o == LAST_IDX) begin
                        state   <= ST_DONE;
                        stim_o  <= '0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        valid_o <= 1'b1;
                        pass_o  <= (d_next == EXP_D) && (e_next == EXP_E);
                    end else begin
                        state     <= ST_SETTLE;
                        vec_idx_o <= vec_idx_o + N_IN'(1);
                        stim_o    <= vec_idx_o + N_IN'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
